// File: rtl/aes_pkg.sv
// AES-128 helpers for the iterative decryptor: GF(2^8) arithmetic, S-boxes, rcon and
// single-step forward/backward key schedule. Bytes are packed most-significant first.
package aes_pkg;

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_ROUND, S_DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse computed as a^254, which also maps zero to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Recovers the previous round key; b3 equals the old last word, which feeds the g() step.
  function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] b0, b1, b2, b3;
    b3 = k[31:0] ^ k[63:32];
    b2 = k[63:32] ^ k[95:64];
    b1 = k[95:64] ^ k[127:96];
    b0 = k[127:96] ^ sub_word(rot_word(b3)) ^ {rc, 24'h000000};
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless the last-round flag is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_last,
  output logic [127:0] o_state
);

  logic [127:0] w_added;
  logic [127:0] w_mixed;

  // Byte n is column n/4, row n%4; row r is rotated right by r columns.
  always_comb begin
    w_added = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_added[127-8*(4*c+r) -: 8] = inv_sbox(i_state[127-8*(4*((c+4-r)%4)+r) -: 8])
                                      ^ i_round_key[127-8*(4*c+r) -: 8];
      end
    end
  end

  always_comb begin
    w_mixed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_mixed[127-8*(4*c+r) -: 8] = gmul(w_added[127-8*(4*c+r) -: 8], 8'h0e)
                                    ^ gmul(w_added[127-8*(4*c+(r+1)%4) -: 8], 8'h0b)
                                    ^ gmul(w_added[127-8*(4*c+(r+2)%4) -: 8], 8'h0d)
                                    ^ gmul(w_added[127-8*(4*c+(r+3)%4) -: 8], 8'h09);
      end
    end
  end

  assign o_state = i_last ? w_added : w_mixed;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key forward to K10, then runs one inverse round
// per clock while walking the key schedule backward. Byte 0 is the most significant byte.
// Define AES_DEC_KEY_CACHE_EN to skip expansion when the previous block's key returns.
module aes128_decrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_ciphertext,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_plaintext
);

  state_t       r_fsm, w_fsm_nxt;
  logic [127:0] r_data, r_key;
  logic [3:0]   r_rnd;
  logic [7:0]   w_rcon;
  logic [127:0] w_key_fwd, w_key_inv, w_round_out;
  logic         w_hit;
  logic [127:0] w_cached_k10;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] r_cached_key, r_cached_k10;
  logic         r_cache_vld;

  // The key is latched at accept but only marked valid once its K10 has been produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_vld  <= 1'b0;
      r_cached_key <= '0;
      r_cached_k10 <= '0;
    end else if (r_fsm == S_IDLE && in_valid && !w_hit) begin
      r_cache_vld  <= 1'b0;
      r_cached_key <= in_key;
    end else if (r_fsm == S_EXPAND && r_rnd == 4'd10) begin
      r_cache_vld  <= 1'b1;
      r_cached_k10 <= w_key_fwd;
    end
  end

  assign w_hit        = r_cache_vld && (in_key == r_cached_key);
  assign w_cached_k10 = r_cached_k10;
`else
  assign w_hit        = 1'b0;
  assign w_cached_k10 = '0;
`endif

  assign w_rcon    = rcon(r_rnd);
  assign w_key_fwd = fwd_expand(r_key, w_rcon);
  assign w_key_inv = inv_expand(r_key, w_rcon);

  aes_inv_round u_inv_round (
    .i_state     (r_data),
    .i_round_key (w_key_inv),
    .i_last      (r_rnd == 4'd1),
    .o_state     (w_round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = w_hit ? S_ROUND : S_EXPAND;
      end
      S_EXPAND: if (r_rnd == 4'd10) w_fsm_nxt = S_ROUND;
      S_ROUND:  if (r_rnd == 4'd1)  w_fsm_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // During EXPAND r_data keeps the ciphertext until K10 is known to whiten it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_key  <= '0;
      r_rnd  <= 4'd0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            if (w_hit) begin
              r_data <= in_ciphertext ^ w_cached_k10;
              r_key  <= w_cached_k10;
              r_rnd  <= 4'd10;
            end else begin
              r_data <= in_ciphertext;
              r_key  <= in_key;
              r_rnd  <= 4'd1;
            end
          end
        end
        S_EXPAND: begin
          r_key <= w_key_fwd;
          if (r_rnd == 4'd10) r_data <= r_data ^ w_key_fwd;
          else                r_rnd  <= r_rnd + 4'd1;
        end
        S_ROUND: begin
          r_data <= w_round_out;
          r_key  <= w_key_inv;
          r_rnd  <= r_rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_plaintext = r_data;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Scoreboard bench for aes128_decrypt_iter: FIPS-197 vectors, backpressure, mid-round
// reset and random blocks produced by an independent table-driven AES encryptor model.
module tb_aes128_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [127:0] inCt = '0;
  logic [127:0] inKey = '0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [127:0] outPt;

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
  } sbEntry_t;

  sbEntry_t     sbq[$];
  int           compared = 0;
  int           mismatched = 0;
  int           cycleCount = 0;
  int           readyMode = 0;
  logic [7:0]   sboxTab [256];
  bit           holding = 1'b0;
  logic [127:0] heldPt = '0;
`ifdef AES_DEC_KEY_CACHE_EN
  bit           modelCacheVld = 1'b0;
  logic [127:0] modelCacheKey = '0;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes128_decrypt_iter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (inValid),
    .in_ready      (inReady),
    .in_ciphertext (inCt),
    .in_key        (inKey),
    .out_valid     (outValid),
    .out_ready     (outReady),
    .out_plaintext (outPt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] randWide();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // S-box from its definition: brute-force inverse followed by the bitwise affine map.
  task automatic buildSbox();
    logic [7:0] inv, b, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sboxTab[x] = b;
    end
  endtask

  function automatic logic [127:0] aesEncrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sboxTab[tmp[23:16]], sboxTab[tmp[15:8]], sboxTab[tmp[7:0]], sboxTab[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = gfMul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sboxTab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gfMul(a0, 8'h02) ^ gfMul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gfMul(a1, 8'h02) ^ gfMul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gfMul(a2, 8'h02) ^ gfMul(a3, 8'h03);
          s[4*c+3] = gfMul(a0, 8'h03) ^ a1 ^ a2 ^ gfMul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Holds the block on the inputs until accepted; the expectation is queued at that moment.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] ct,
                               input logic [127:0] pt, output int acc);
    sbEntry_t e;
    bit       done;
    acc  = -1;
    done = 1'b0;
    @(posedge clk); #2;
    inValid = 1'b1;
    inKey   = key;
    inCt    = ct;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (inReady) begin
        done  = 1'b1;
        acc   = cycleCount;
        e.pt  = pt;
        e.acc = cycleCount;
        e.lat = 21;
`ifdef AES_DEC_KEY_CACHE_EN
        if (modelCacheVld && key == modelCacheKey) e.lat = 11;
        modelCacheVld = 1'b1;
        modelCacheKey = key;
`endif
        sbq.push_back(e);
      end
    end
    if (!done) checkOutput("accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #2;
    inValid = 1'b0;
    inKey   = randWide();
    inCt    = randWide();
  endtask

  task automatic waitDrain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (sbq.size() == 0 && inReady) ok = 1'b1;
    end
    if (!ok) checkOutput("drain_timeout", 128'd0, 128'd1);
  endtask

  initial forever begin
    @(posedge clk); #3;
    case (readyMode)
      0:       outReady = 1'b0;
      1:       outReady = 1'b1;
      default: outReady = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: first cycle of out_valid pops and checks; later cycles check the hold.
  always @(negedge clk) begin
    sbEntry_t e;
    if (!rst_n || !outValid) begin
      holding = 1'b0;
    end else begin
      if (!holding) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_output", outPt, 128'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput("plaintext", outPt, e.pt);
          checkOutput("latency", 128'(cycleCount - e.acc), 128'(e.lat));
        end
        holding = 1'b1;
        heldPt  = outPt;
      end else begin
        checkOutput("held_plaintext", outPt, heldPt);
      end
      checkOutput("in_ready_while_done", 128'(inReady), 128'd0);
      if (outReady) holding = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: time limit reached, %0d compared / %0d mismatched", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] k, kPrev, pt, ct;
    int           acc, acc2;
    buildSbox();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 128'(inReady), 128'd1);
    checkOutput("reset_out_valid", 128'(outValid), 128'd0);
    checkOutput("reset_out_plaintext", outPt, 128'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    $display("[TB] FIPS-197 vectors");
    readyMode = 1;
    applyStimulus(C1_KEY, C1_CT, C1_PT, acc);
    applyStimulus(C1_KEY, C1_CT, C1_PT, acc);
    applyStimulus(B_KEY, B_CT, B_PT, acc);
    waitDrain();

    $display("[TB] output backpressure with a pending input");
    readyMode = 0;
    applyStimulus(C1_KEY, C1_CT, C1_PT, acc);
    fork
      applyStimulus(B_KEY, B_CT, B_PT, acc2);
      begin
        for (int n = 0; n < 100 && !outValid; n++) @(negedge clk);
        checkOutput("bp_out_valid_seen", 128'(outValid), 128'd1);
        repeat (5) @(negedge clk);
        @(posedge clk); #2;
        readyMode = 1;
      end
    join
    waitDrain();

    $display("[TB] reset in the middle of ROUND");
    applyStimulus(C1_KEY, C1_CT, C1_PT, acc);
    while (cycleCount < acc + 15) @(negedge clk);
    #1 rst_n = 1'b0;
    sbq.delete();
`ifdef AES_DEC_KEY_CACHE_EN
    modelCacheVld = 1'b0;
`endif
    #1;
    checkOutput("midrst_out_valid", 128'(outValid), 128'd0);
    checkOutput("midrst_in_ready", 128'(inReady), 128'd1);
    checkOutput("midrst_out_plaintext", outPt, 128'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    applyStimulus(C1_KEY, C1_CT, C1_PT, acc);
    waitDrain();

    $display("[TB] random blocks");
    readyMode = 2;
    kPrev = randWide();
    for (int n = 0; n < 1000; n++) begin
      k     = ($urandom_range(0, 3) == 0) ? kPrev : randWide();
      kPrev = k;
      pt    = randWide();
      ct    = aesEncrypt(k, pt);
      applyStimulus(k, ct, pt, acc);
    end
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
